// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_ctrl
// Purpose  : Scan sequencer for a 4x4 matrix keypad. Drives one column low at
//            a time, samples the (synchronised) rows once per column dwell,
//            debounces both the press and the release, and reports each newly
//            accepted key as a 4-bit hex code with a one-cycle strobe.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SCAN_DIV   : cclk cycles each column is driven (dwell), minimum 4
//   DEBOUNCE_N : consecutive matching dwell-end samples needed to accept a
//                press or a release, minimum 1
// Ports
//   cclk      in   1  system clock
//   rst       in   1  asynchronous reset, active low
//   kypd_row  in   4  keypad rows, active low, asynchronous to cclk
//   kypd_col  out  4  column drive, one-hot-low (1110,1101,1011,0111)
//   key_code  out  4  hex code of the last accepted key (held until next)
//   key_valid out  1  one-cycle pulse when key_code is updated
//   key_held  out  1  high while the accepted key is debounced-pressed
// Key map (column, row 0..3)
//   col0: 1 4 7 0   col1: 2 5 8 F   col2: 3 6 9 E   col3: A B C D
// ============================================================================
module keypad_scan_ctrl #(
  parameter int SCAN_DIV   = 100000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic       cclk,
  input  logic       rst,
  input  logic [3:0] kypd_row,
  output logic [3:0] kypd_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int c_cnt_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_deb_w = $clog2(DEBOUNCE_N + 1);

  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(SCAN_DIV - 1);
  localparam logic [c_deb_w-1:0] c_deb_one   = c_deb_w'(1);
  localparam logic [c_deb_w-1:0] c_deb_target = c_deb_w'(DEBOUNCE_N);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [3:0]         r_row_meta;
  logic [3:0]         r_row_s;
  logic [c_cnt_w-1:0] r_cnt;
  logic [1:0]         r_col_idx;
  state_t             r_state;
  logic [c_deb_w-1:0] r_deb_cnt;
  logic [3:0]         r_cap_row;
  logic [3:0]         r_key_code;
  logic               r_key_valid;
  logic               r_key_held;

  // --------------------------------------------------------------------------
  // Next-state wires
  // --------------------------------------------------------------------------
  state_t             w_state_nxt;
  logic [1:0]         w_col_nxt;
  logic [c_deb_w-1:0] w_deb_nxt;
  logic [3:0]         w_cap_nxt;
  logic [3:0]         w_code_nxt;
  logic               w_valid_nxt;
  logic               w_held_nxt;

  logic               w_sample;
  logic               w_single;
  logic [c_deb_w-1:0] w_deb_inc;

  // Map a frozen column index and a single-low row pattern to the hex code.
  function automatic logic [3:0] f_key_map(input logic [1:0] col,
                                           input logic [3:0] row);
    logic [1:0] ridx;
    logic [3:0] code;
    case (row)
      4'b1101: ridx = 2'd1;
      4'b1011: ridx = 2'd2;
      4'b0111: ridx = 2'd3;
      default: ridx = 2'd0;
    endcase
    case ({col, ridx})
      4'h0: code = 4'h1;
      4'h1: code = 4'h4;
      4'h2: code = 4'h7;
      4'h3: code = 4'h0;
      4'h4: code = 4'h2;
      4'h5: code = 4'h5;
      4'h6: code = 4'h8;
      4'h7: code = 4'hF;
      4'h8: code = 4'h3;
      4'h9: code = 4'h6;
      4'hA: code = 4'h9;
      4'hB: code = 4'hE;
      4'hC: code = 4'hA;
      4'hD: code = 4'hB;
      4'hE: code = 4'hC;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // --------------------------------------------------------------------------
  // Row synchroniser and dwell counter
  // --------------------------------------------------------------------------
  always_ff @(posedge cclk or negedge rst) begin
    if (!rst) begin
      r_row_meta <= 4'hF;
      r_row_s    <= 4'hF;
      r_cnt      <= '0;
    end else begin
      r_row_meta <= kypd_row;
      r_row_s    <= r_row_meta;
      r_cnt      <= w_sample ? '0 : r_cnt + 1'b1;
    end
  end

  assign w_sample  = (r_cnt == c_cnt_last);
  assign w_deb_inc = r_deb_cnt + 1'b1;

  // Exactly one row low; anything else (idle or ghosting) counts as no key.
  always_comb begin
    w_single = 1'b0;
    case (r_row_s)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: w_single = 1'b1;
      default:                            w_single = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge cclk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_SCAN;
      r_col_idx   <= 2'd0;
      r_deb_cnt   <= '0;
      r_cap_row   <= 4'hF;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col_idx   <= w_col_nxt;
      r_deb_cnt   <= w_deb_nxt;
      r_cap_row   <= w_cap_nxt;
      r_key_code  <= w_code_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_held  <= w_held_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state / output logic. Everything changes only at a sample point,
  // so the column (and the strobe) update on the cycle after it. The column
  // stays frozen outside SCAN, so r_col_idx doubles as the captured column.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col_idx;
    w_deb_nxt   = r_deb_cnt;
    w_cap_nxt   = r_cap_row;
    w_code_nxt  = r_key_code;
    w_valid_nxt = 1'b0;
    w_held_nxt  = r_key_held;

    if (w_sample) begin
      case (r_state)
        ST_SCAN: begin
          if (w_single) begin
            w_cap_nxt = r_row_s;
            if (c_deb_target == c_deb_one) begin
              // Single-sample debounce: the detecting sample also accepts.
              w_state_nxt = ST_HELD;
              w_deb_nxt   = '0;
              w_code_nxt  = f_key_map(r_col_idx, r_row_s);
              w_valid_nxt = 1'b1;
              w_held_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_DEBOUNCE;
              w_deb_nxt   = c_deb_one;
            end
          end else begin
            w_col_nxt = r_col_idx + 2'd1;
          end
        end

        ST_DEBOUNCE: begin
          if (r_row_s == r_cap_row) begin
            if (w_deb_inc == c_deb_target) begin
              w_state_nxt = ST_HELD;
              w_deb_nxt   = '0;
              w_code_nxt  = f_key_map(r_col_idx, r_row_s);
              w_valid_nxt = 1'b1;
              w_held_nxt  = 1'b1;
            end else begin
              w_deb_nxt = w_deb_inc;
            end
          end else begin
            w_state_nxt = ST_SCAN;
            w_deb_nxt   = '0;
            w_col_nxt   = r_col_idx + 2'd1;
          end
        end

        ST_HELD: begin
          // Release counter: only consecutive all-high samples count.
          if (r_row_s == 4'hF) begin
            if (w_deb_inc == c_deb_target) begin
              w_state_nxt = ST_SCAN;
              w_deb_nxt   = '0;
              w_held_nxt  = 1'b0;
              w_col_nxt   = r_col_idx + 2'd1;
            end else begin
              w_deb_nxt = w_deb_inc;
            end
          end else begin
            w_deb_nxt = '0;
          end
        end

        default: begin
          w_state_nxt = ST_SCAN;
          w_deb_nxt   = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign kypd_col  = ~(4'b0001 << r_col_idx);
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_ctrl
// Purpose  : Self-checking bench for keypad_scan_ctrl. A physical keypad
//            model turns the set of pressed keys into row levels, and a
//            sample-point reference model predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV   = 8;
  localparam int DEBOUNCE_N = 3;
  localparam int LATENCY    = (DEBOUNCE_N - 1) * SCAN_DIV + 1;

  localparam int M_SCAN    = 0;
  localparam int M_CONFIRM = 1;
  localparam int M_HELD    = 2;

  logic        cclk = 1'b0;
  logic        rst;
  logic [3:0]  kypd_row;
  logic [3:0]  kypd_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = '0;   // bit col*4+row set = that key is down

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = 0;
  int cyc = 0;

  typedef struct {
    int         cnt;
    int         col;
    int         mode;
    int         streak;
    logic [3:0] pat;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] code;
    logic       valid;
    logic       held;
    int         detect_cyc;
  } model_t;

  model_t m;

  keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_N(DEBOUNCE_N)) dut (
    .cclk      (cclk),
    .rst       (rst),
    .kypd_row  (kypd_row),
    .kypd_col  (kypd_col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 cclk = ~cclk;
  always @(posedge cclk) cyc <= cyc + 1;

  // Keypad layout, position = col*4 + row.
  function automatic logic [3:0] key_at(int pos);
    logic [63:0] t;
    t = 64'hDCBA_E963_F852_0741;
    return t[pos*4 +: 4];
  endfunction

  function automatic int pos_of(logic [3:0] hex);
    int p;
    p = 0;
    for (int i = 0; i < 16; i++) if (key_at(i) == hex) p = i;
    return p;
  endfunction

  function automatic int row_of(logic [3:0] pat);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (!pat[i]) r = i;
    return r;
  endfunction

  // Passive matrix: a pressed key shorts its row to a column driven low.
  function automatic logic [3:0] keypad_rows(logic [3:0] cols, logic [15:0] pr);
    logic [3:0] r;
    r = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!cols[c])
        for (int k = 0; k < 4; k++)
          if (pr[c*4+k]) r[k] = 1'b0;
    return r;
  endfunction

  assign kypd_row = keypad_rows(kypd_col, pressed);

  function automatic model_t model_reset();
    model_t n;
    n.cnt = 0; n.col = 0; n.mode = M_SCAN; n.streak = 0;
    n.pat = 4'hF; n.s1 = 4'hF; n.s2 = 4'hF;
    n.code = 4'h0; n.valid = 1'b0; n.held = 1'b0; n.detect_cyc = 0;
    return n;
  endfunction

  // One clock of the behaviour: rows reach the decision point two edges late,
  // and decisions are taken only on the last cycle of each dwell.
  function automatic model_t model_step(model_t c, logic [3:0] phys, int now);
    model_t     n;
    logic [3:0] seen;
    bit         take;
    n = c;
    n.valid = 1'b0;
    take = 1'b0;
    seen = c.s2;
    n.s2 = c.s1;
    n.s1 = phys;
    n.cnt = (c.cnt + 1) % SCAN_DIV;
    if (c.cnt == SCAN_DIV - 1) begin
      if (c.mode == M_SCAN) begin
        if ($countones(~seen) == 1) begin
          n.pat = seen; n.detect_cyc = now; n.streak = 1; n.mode = M_CONFIRM;
          take = (DEBOUNCE_N == 1);
        end else begin
          n.col = (c.col + 1) % 4;
        end
      end else if (c.mode == M_CONFIRM) begin
        if (seen == c.pat) begin
          n.streak = c.streak + 1;
          take = (n.streak >= DEBOUNCE_N);
        end else begin
          n.mode = M_SCAN; n.col = (c.col + 1) % 4;
        end
      end else begin
        n.streak = (seen == 4'hF) ? c.streak + 1 : 0;
        if (n.streak >= DEBOUNCE_N) begin
          n.held = 1'b0; n.mode = M_SCAN; n.col = (c.col + 1) % 4;
        end
      end
      if (take) begin
        n.mode = M_HELD; n.streak = 0; n.valid = 1'b1; n.held = 1'b1;
        n.code = key_at(c.col * 4 + row_of(seen));
      end
    end
    return n;
  endfunction

  always @(posedge cclk or negedge rst) begin
    if (!rst) m <= model_reset();
    else      m <= model_step(m, keypad_rows(4'b1111 ^ (4'b0001 << m.col), pressed), cyc);
  end

  task automatic expect4(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_int(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [3:0] ecol;
    ecol = 4'b1111 ^ (4'b0001 << m.col);
    checks++;
    assert (kypd_col === ecol) else begin
      errors++; $error("FAIL kypd_col cyc=%0d observed=%b expected=%b", cyc, kypd_col, ecol);
    end
    checks++;
    assert (key_code === m.code) else begin
      errors++; $error("FAIL key_code cyc=%0d observed=%h expected=%h", cyc, key_code, m.code);
    end
    checks++;
    assert (key_valid === m.valid) else begin
      errors++; $error("FAIL key_valid cyc=%0d observed=%b expected=%b", cyc, key_valid, m.valid);
    end
    checks++;
    assert (key_held === m.held) else begin
      errors++; $error("FAIL key_held cyc=%0d observed=%b expected=%b", cyc, key_held, m.held);
    end
    if (key_valid === 1'b1) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
    end
  endtask

  task automatic tick(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge cclk);
      check_outputs();
    end
  endtask

  task automatic wait_held(logic lvl, int budget, string tag);
    int n;
    n = 0;
    while (key_held !== lvl && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    assert (key_held === lvl) else begin
      errors++; $error("FAIL %s timeout key_held observed=%b expected=%b", tag, key_held, lvl);
    end
  endtask

  task automatic wait_mode(int mode, int budget, string tag);
    int n;
    n = 0;
    while (m.mode != mode && n < budget) begin
      tick(1);
      n++;
    end
    expect_int(tag, m.mode, mode);
  endtask

  task automatic press(logic [3:0] hex);
    pressed[pos_of(hex)] = 1'b1;
  endtask

  initial begin
    int p0;
    rst = 1'b0;
    pressed = '0;
    tick(3);

    // Reset values
    expect4("rst_col", kypd_col, 4'b1110);
    expect4("rst_code", key_code, 4'h0);
    expect4("rst_valid", {3'b0, key_valid}, 4'h0);
    expect4("rst_held", {3'b0, key_held}, 4'h0);

    // 1. Idle scan rotation, one column per dwell
    rst = 1'b1;
    tick(4);  expect4("scan_c0", kypd_col, 4'b1110);
    tick(8);  expect4("scan_c1", kypd_col, 4'b1101);
    tick(8);  expect4("scan_c2", kypd_col, 4'b1011);
    tick(8);  expect4("scan_c3", kypd_col, 4'b0111);
    tick(8);  expect4("scan_wrap", kypd_col, 4'b1110);
    p0 = pulse_cnt;
    tick(100);
    expect_int("idle_no_pulse", pulse_cnt, p0);

    // 2. Key 5: accept, latency, release
    p0 = pulse_cnt;
    press(4'h5);
    wait_held(1'b1, 200, "k5_press");
    expect4("k5_col", kypd_col, 4'b1101);
    expect4("k5_code", key_code, 4'h5);
    tick(30);
    expect_int("k5_one_pulse", pulse_cnt - p0, 1);
    expect_int("k5_latency", last_pulse_cyc - m.detect_cyc, LATENCY);
    pressed = '0;
    wait_held(1'b0, 100, "k5_release");
    expect4("k5_resume_col", kypd_col, 4'b1011);
    expect4("k5_code_kept", key_code, 4'h5);

    // 3. Bounce on D: seen for one sample only
    p0 = pulse_cnt;
    press(4'hD);
    wait_mode(M_CONFIRM, 100, "bounce_detect");
    pressed = '0;
    tick(10);
    expect4("bounce_col", kypd_col, 4'b1110);
    expect_int("bounce_no_pulse", pulse_cnt, p0);

    // 4. Ghosting: two rows low in column 0
    p0 = pulse_cnt;
    press(4'h1);
    press(4'h4);
    tick(80);
    expect_int("ghost_no_pulse", pulse_cnt, p0);
    expect4("ghost_not_held", {3'b0, key_held}, 4'h0);
    pressed = '0;
    tick(10);

    // 5. No rollover: A held, 3 pressed too
    p0 = pulse_cnt;
    press(4'hA);
    wait_held(1'b1, 200, "ka_press");
    press(4'h3);
    tick(40);
    expect_int("rollover_one_pulse", pulse_cnt - p0, 1);
    expect4("rollover_held", {3'b0, key_held}, 4'h1);
    pressed = '0;
    wait_held(1'b0, 100, "ka_release");
    expect4("ka_code_kept", key_code, 4'hA);

    // 6. Reset mid-debounce, key 0 still down afterwards
    tick(5);
    press(4'h0);
    wait_mode(M_CONFIRM, 100, "k0_detect");
    tick(3);
    rst = 1'b0;
    #1;
    expect4("mid_rst_col", kypd_col, 4'b1110);
    expect4("mid_rst_code", key_code, 4'h0);
    expect4("mid_rst_valid", {3'b0, key_valid}, 4'h0);
    expect4("mid_rst_held", {3'b0, key_held}, 4'h0);
    tick(2);
    rst = 1'b1;
    p0 = pulse_cnt;
    wait_held(1'b1, 200, "k0_press");
    expect4("k0_code", key_code, 4'h0);
    expect_int("k0_one_pulse", pulse_cnt - p0, 1);
    pressed = '0;
    wait_held(1'b0, 100, "k0_release");

    // Randomised presses, bounces, extra keys and resets
    for (int it = 0; it < 40; it++) begin
      pressed = '0;
      press(4'($urandom_range(15)));
      if ($urandom_range(3) == 0) pressed[$urandom_range(15)] = 1'b1;
      tick($urandom_range(4, 60));
      if ($urandom_range(3) == 0) begin
        pressed = '0;
        tick($urandom_range(1, 12));
        press(4'($urandom_range(15)));
        tick($urandom_range(4, 40));
      end
      if ($urandom_range(9) == 0) begin
        rst = 1'b0;
        tick($urandom_range(1, 3));
        rst = 1'b1;
        tick($urandom_range(4, 40));
      end
      pressed = '0;
      tick($urandom_range(10, 70));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Scan sequencer for the 4x4 matrix keypad.
- Drives the column lines one at a time and samples the row lines, then debounces the press and the release.
- Reports each new press as a 4-bit hex code with a single-cycle strobe. Code map: col0 rows 1,4,7,0; col1 rows 2,5,8,F; col2 rows 3,6,9,E; col3 rows A,B,C,D.
- Feeds the recorder control FSM, which consumes key_valid/key_code as commands.

Parameters:
SCAN_DIV, 100000, cclk cycles each column is driven (dwell); minimum 4.
DEBOUNCE_N, 4, consecutive matching dwell-end samples needed to accept a press or a release; minimum 1.

Ports:
cclk  input  1  system clock.
rst  input  1  asynchronous, active-low reset.
kypd_row  input  4  keypad rows, active-low, asynchronous to cclk.
kypd_col  output  4  column drive, one-hot-low (1110, 1101, 1011, 0111).
key_code  output  4  hex code of last accepted key; holds its value until the next accepted key.
key_valid  output  1  one-cycle pulse when key_code is updated.
key_held  output  1  high while the accepted key is debounced-pressed.

Behaviour:
- Reset (rst=0, async):
  - kypd_col=1110, key_code=0, key_valid=0, key_held=0.
  - State=SCAN; dwell counter, debounce counter and sync flops cleared (sync flops to 1111).
- Row synchroniser:
  - kypd_row passes through a 2-flop synchroniser to give row_s.
  - All decisions use row_s.
- Dwell counter:
  - Counts 0..SCAN_DIV-1, then wraps.
  - "Sample point" = cycle where count==SCAN_DIV-1. row_s is evaluated only there.
  - The column may change only on the cycle after a sample point.
- SCAN:
  - At a sample point, if row_s has exactly one 0 bit: capture col index and row pattern, set debounce counter=1, go to DEBOUNCE. Column does not advance.
  - Otherwise (1111, or multiple zeros = ghosting) the column rotates 1110->1101->1011->0111->1110.
- DEBOUNCE (column frozen):
  - At each sample point, if row_s == captured pattern, increment the counter.
  - When the counter reaches DEBOUNCE_N: go to HELD, load key_code from the map, assert key_valid for exactly one cycle (the cycle after the sample point), set key_held=1.
  - With DEBOUNCE_N=1 the acceptance happens in the SCAN sample that detected the key.
  - Mismatch: back to SCAN, column advances, no output change.
- HELD (column frozen):
  - At each sample point, row_s==1111 increments the release counter; any other value clears it.
  - When the release counter reaches DEBOUNCE_N: key_held=0, go to SCAN, column advances.
  - key_code is retained.
  - A second key pressed while held produces no event (no rollover).
- key_valid:
  - Never asserted in SCAN.
  - Never asserted twice for one press.
  - A new press of the same key after release produces a new pulse.
- Reset mid-operation: immediate return to reset values regardless of state; a key still down after reset release is re-detected from SCAN normally.
- Press-to-strobe latency, measured from the first detecting sample point: (DEBOUNCE_N-1)*SCAN_DIV + 1 cycles.

Test Plan (SCAN_DIV=8, DEBOUNCE_N=3):
1. Reset, no key -> kypd_col steps 1110,1101,1011,0111,1110 every 8 cycles; key_valid stays 0 for 100 cycles.
2. Hold key "5" (row 1101 while col==1101) -> column freezes at 1101, key_valid pulses once 17 cycles after the detect sample, key_code=4'h5, key_held=1. Release -> key_held=0 after 3 clean samples, scan resumes at 1011.
3. Bounce: key "D" (col 0111, row 0111) present for 1 sample then absent -> no key_valid, scan resumes at 1110.
4. Two rows low in one column (row=1100) -> treated as no key, column advances, no event.
5. During HELD on "A", also press "3" -> no second pulse. Release both -> key_held drops, key_code stays 4'hA.
6. Assert rst mid-DEBOUNCE -> outputs zero immediately, kypd_col=1110. Deassert with key "0" held -> accepted normally, key_code=4'h0 with a key_valid pulse.
